// File: rtl/pdm_demod_pkg.sv
// Shared constants and helpers for the PDM demodulator: derived widths,
// output scaling shift, saturation ceiling and parameter legality.
package pdm_demod_pkg;

    // Internal CIC width: two integrator stages of growth LOG2_DECIM each plus one bit.
    function automatic int calc_w(input int log2_decim);
        return 2 * log2_decim + 1;
    endfunction

    // Right shift that maps the R^2 full scale onto the NBITS output range.
    function automatic int calc_shift(input int nbits, input int log2_decim);
        return 2 * log2_decim - nbits;
    endfunction

    // Largest representable full-scale value before the shift, 2^(2*LOG2_DECIM)-1.
    function automatic longint calc_ymax(input int log2_decim);
        return (longint'(1) << (2 * log2_decim)) - 1;
    endfunction

    // Legal parameter set: decimation 4..32768 and enough CIC bits to fill NBITS.
    function automatic bit params_legal(input int nbits, input int log2_decim);
        return (log2_decim >= 2) && (log2_decim <= 15) && (2 * log2_decim >= nbits);
    endfunction

endpackage

// File: rtl/pdm_demod_comb.sv
// Single CIC comb stage: on each strobe, registers the difference between the
// new sample and the previous one, and forwards the strobe one cycle later.
module pdm_demod_comb
    import pdm_demod_pkg::*;
#(
    parameter int W = 13
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_stb,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_diff,
    output logic         o_stb
);

    logic [W-1:0] r_diff;
    logic [W-1:0] r_dly;
    logic         r_stb;

    // Modulo-2^W difference against the previous sample; wrap-around is intended.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_diff <= '0;
            r_dly  <= '0;
            r_stb  <= 1'b0;
        end else begin
            r_stb <= i_stb;
            if (i_stb) begin
                r_diff <= i_data - r_dly;
                r_dly  <= i_data;
            end
        end
    end

    assign o_diff = r_diff;
    assign o_stb  = r_stb;

endmodule

// File: rtl/pdm_demod.sv
// Pulse-density demodulator: second-order CIC decimator (ratio 2^LOG2_DECIM)
// with saturation to full scale and a right shift down to NBITS.
module pdm_demod
    import pdm_demod_pkg::*;
#(
    parameter int NBITS      = 11,
    parameter int LOG2_DECIM = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             din,
    output logic [NBITS-1:0] dout,
    output logic             dout_valid
);

    localparam int W     = calc_w(LOG2_DECIM);
    localparam int SHIFT = calc_shift(NBITS, LOG2_DECIM);
    // YMAX is 2^(W-1)-1, i.e. all ones below the top bit.
    localparam logic [W-1:0] YMAX = {1'b0, {(W-1){1'b1}}};

    if (!params_legal(NBITS, LOG2_DECIM)) begin : g_param_check
        $error("pdm_demod: need 2 <= LOG2_DECIM <= 15 and 2*LOG2_DECIM >= NBITS");
    end

    logic                  r_din;
    logic [W-1:0]          r_int1;
    logic [W-1:0]          r_int2;
    logic [LOG2_DECIM-1:0] r_cnt;
    logic [W-1:0]          r_samp;
    logic                  r_stb1;
    logic [NBITS-1:0]      r_dout;
    logic                  r_dout_valid;

    logic                  w_decim;
    logic [W-1:0]          w_c1;
    logic                  w_stb2;
    logic [W-1:0]          w_c2;
    logic                  w_stb3;

    // Clamp the all-ones case (exactly R^2) to full scale, then drop to NBITS.
    function automatic logic [NBITS-1:0] sat_scale(input logic [W-1:0] x);
        logic [W-1:0] y;
        y = (x > YMAX) ? YMAX : x;
        return NBITS'(y >> SHIFT);
    endfunction

    assign w_decim = en && (r_cnt == '1);

    // Input register and the two integrators; all hold while en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_din  <= 1'b0;
            r_int1 <= '0;
            r_int2 <= '0;
        end else if (en) begin
            r_din  <= din;
            r_int1 <= r_int1 + {{(W-1){1'b0}}, r_din};
            r_int2 <= r_int2 + r_int1;
        end
    end

    // Decimation counter; the last count of each window captures int2 and fires the comb chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_samp <= '0;
            r_stb1 <= 1'b0;
        end else begin
            r_stb1 <= w_decim;
            if (w_decim) begin
                r_cnt  <= '0;
                r_samp <= r_int2;
            end else if (en) begin
                r_cnt  <= r_cnt + LOG2_DECIM'(1);
            end
        end
    end

    pdm_demod_comb #(.W(W)) u_comb1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_stb  (r_stb1),
        .i_data (r_samp),
        .o_diff (w_c1),
        .o_stb  (w_stb2)
    );

    pdm_demod_comb #(.W(W)) u_comb2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_stb  (w_stb2),
        .i_data (w_c1),
        .o_diff (w_c2),
        .o_stb  (w_stb3)
    );

    // Output scaler: update the sample on the final comb strobe, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            r_dout_valid <= w_stb3;
            if (w_stb3) begin
                r_dout <= sat_scale(w_c2);
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;

endmodule

// File: doc/pdm_demod.md
# pdm_demod

Pulse-density demodulator. Recovers an NBITS-wide sample stream from a 1-bit PDM stream with a second-order CIC decimator of ratio R = 2**LOG2_DECIM, followed by saturation and scaling. It is the receive-side counterpart of the pdm modulator: it sits after a PDM comparator or loopback and feeds the sample-rate datapath.

## Interface
- NBITS, 11: output sample width.
- LOG2_DECIM, 6: log2 of the decimation ratio R. Legal range is 2..15. Requires 2*LOG2_DECIM >= NBITS.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  input-sample enable; one PDM bit is consumed per clk while high.
- din  in  1  PDM bit stream.
- dout  out  NBITS  demodulated sample, unsigned.
- dout_valid  out  1  one-cycle strobe when dout updates.

## Operation
- Internal width W = 2*LOG2_DECIM+1. Integrators and combs use modulo-2^W arithmetic; wrap-around is intended and must not be saturated.
- Input stage: din_reg <= din when en.
- Integrators (en high only): int1 <= int1 + din_reg; int2 <= int2 + int1.
- Decimation counter cnt, LOG2_DECIM bits:
  - Counts 0..R-1 on en.
  - On the edge where cnt = R-1 and en = 1: cnt <= 0, samp <= int2 (pre-update value), stb1 <= 1.
  - Otherwise stb1 <= 0.
- Comb pipeline runs every clk, independent of en:
  - On stb1: c1 <= samp - samp_d; samp_d <= samp; stb2 <= 1.
  - On stb2: c2 <= c1 - c1_d; c1_d <= c1; stb3 <= 1.
  - On stb3: dout <= min(c2, 2^(2*LOG2_DECIM)-1) >> (2*LOG2_DECIM-NBITS); dout_valid <= 1.
- Steady-state c2 = (number of ones in the window) scaled by R^2. All-ones gives R^2, which saturates to R^2-1.
- en low: cnt, din_reg and integrators hold. An in-flight comb/strobe sequence still completes.
- Transient: the first two dout_valid outputs after reset are start-up transients. For constant-density input, dout is exact from the third output onward.

## Timing
- Reset (rst_n low, any time): every register, including dout, dout_valid, cnt, integrators, combs and strobes, clears to 0 immediately. Reset wins over en.
- Reset mid-operation discards any partial window. Counting restarts at cnt = 0 on the first en edge after release.
- dout_valid asserts exactly 3 clk after the decimation edge, for 1 cycle.
- With en held high, dout_valid period is exactly R cycles. The first pulse comes on the (R+3)-th clk edge after rst_n deasserts.
- dout holds its value between strobes.

## Structure
- Shared package or header holds:
  - derived constants W, SHIFT = 2*LOG2_DECIM-NBITS and YMAX = 2^(2*LOG2_DECIM)-1;
  - a parameter-legality check that fails elaboration if 2*LOG2_DECIM < NBITS or LOG2_DECIM < 2.
- One sub-module, pdm_demod_comb: a W-bit single comb stage (strobe in, registered difference, delayed-value register, strobe out). It is instantiated twice.
- Integrators, counter and output scaler live in the top.

## Test plan
Defaults unless stated (NBITS=11, R=64).
- All-ones, en=1 -> dout_valid every 64 cycles, first on edge 67 after reset release; dout = 2047 from the third strobe.
- All-zeros -> dout = 0 on every strobe.
- Pattern 1010…, and pattern 1000 repeating -> dout = 1024 and 512 respectively, from the third strobe.
- en toggled 1/0 every cycle with all-ones -> strobe period 128 cycles; steady dout = 2047.
- Loopback from the pdm modulator (NBITS=11) with modulator input 1024 -> steady dout within 1024±4. With input 0 -> steady dout = 0.
- rst_n pulsed low mid-window (cnt=30) -> dout and dout_valid read 0 during reset. The next strobe falls 67 edges after release, and the third strobe after release is exact again.
